esl_bus_multi_counter: RTL and testbench

//   Avalon-MM slave hosting N_CHANNELS independent programmable counters.

---
 rtl/esl_bus_multi_counter.sv | 194 +++++++++++++++++++
 tb/tb_esl_bus_multi_counter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/esl_bus_multi_counter.sv
// Avalon-MM slave hosting N_CHANNELS programmable up/down counters with LED taps.
// Optional: define ESL_BUS_IRQ_EN to add the per-channel IRQ_EN control bit and the irq output.
module esl_bus_multi_counter #(
  parameter int N_CHANNELS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 24,
  parameter int LED_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [7:0]                       slave_address,
  input  logic                             slave_read,
  output logic [DATA_WIDTH-1:0]            slave_readdata,
  input  logic                             slave_write,
  input  logic [DATA_WIDTH-1:0]            slave_writedata,
  input  logic [DATA_WIDTH/8-1:0]          slave_byteenable,
  output logic [N_CHANNELS*LED_WIDTH-1:0]  user_output
`ifdef ESL_BUS_IRQ_EN
  ,
  output logic                             irq
`endif
);

  localparam int NB = DATA_WIDTH / 8;
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  cnt_t count   [N_CHANNELS];
  cnt_t count_n [N_CHANNELS];
  cnt_t limit   [N_CHANNELS];
  cnt_t limit_n [N_CHANNELS];
  logic en      [N_CHANNELS];
  logic en_n    [N_CHANNELS];
  logic down    [N_CHANNELS];
  logic down_n  [N_CHANNELS];
  logic auto_rl   [N_CHANNELS];
  logic auto_rl_n [N_CHANNELS];
  logic wrap    [N_CHANNELS];
  logic wrap_n  [N_CHANNELS];
  logic ien     [N_CHANNELS];
`ifdef ESL_BUS_IRQ_EN
  logic ien_n   [N_CHANNELS];
`endif

  logic [5:0]            ch;
  logic [1:0]            reg_sel;
  logic [DATA_WIDTH-1:0] rd;

  assign ch      = slave_address[7:2];
  assign reg_sel = slave_address[1:0];

  // Replace only the byte lanes whose enable is set.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_val;
    for (int b = 0; b < NB; b++)
      if (be[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
    return r;
  endfunction

  // Next-state: W1C first, then counting (terminal event may re-set WRAP), then bus writes.
  always_comb begin
    logic [DATA_WIDTH-1:0] m;
    logic                  hit;
    logic                  term;
    m    = '0;
    hit  = 1'b0;
    term = 1'b0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      count_n[k]   = count[k];
      limit_n[k]   = limit[k];
      en_n[k]      = en[k];
      down_n[k]    = down[k];
      auto_rl_n[k] = auto_rl[k];
      wrap_n[k]    = wrap[k];
`ifdef ESL_BUS_IRQ_EN
      ien_n[k]     = ien[k];
`endif
      hit  = slave_write && (ch == 6'(k));
      term = 1'b0;

      if (hit && reg_sel == 2'd3 && slave_byteenable[0] && slave_writedata[0])
        wrap_n[k] = 1'b0;

      if (en[k] && !(hit && reg_sel == 2'd2)) begin
        if (down[k]) begin
          term       = (count[k] == '0);
          count_n[k] = term ? limit[k] : count[k] - cnt_t'(1);
        end else begin
          term       = (count[k] == limit[k]);
          count_n[k] = term ? '0 : count[k] + cnt_t'(1);
        end
        if (term) begin
          wrap_n[k] = 1'b1;
          if (!auto_rl[k]) en_n[k] = 1'b0;
        end
      end

      if (hit) begin
        case (reg_sel)
          2'd0: begin
            m = merge_bytes(DATA_WIDTH'({ien[k], auto_rl[k], down[k], en[k]}),
                            slave_writedata, slave_byteenable);
            en_n[k]      = m[0];
            down_n[k]    = m[1];
            auto_rl_n[k] = m[2];
`ifdef ESL_BUS_IRQ_EN
            ien_n[k]     = m[3];
`endif
          end
          2'd1: begin
            m = merge_bytes(DATA_WIDTH'(limit[k]), slave_writedata, slave_byteenable);
            limit_n[k] = m[CNT_WIDTH-1:0];
          end
          2'd2: begin
            m = merge_bytes(DATA_WIDTH'(count[k]), slave_writedata, slave_byteenable);
            count_n[k] = m[CNT_WIDTH-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  // Read mux; channels outside the populated range fall through to zero.
  always_comb begin
    rd = '0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      if (ch == 6'(k)) begin
        case (reg_sel)
          2'd0:    rd[3:0]           = {ien[k], auto_rl[k], down[k], en[k]};
          2'd1:    rd[CNT_WIDTH-1:0] = limit[k];
          2'd2:    rd[CNT_WIDTH-1:0] = count[k];
          default: rd[1:0]           = {en[k], wrap[k]};
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slave_readdata <= '0;
      for (int k = 0; k < N_CHANNELS; k++) begin
        count[k]   <= '0;
        limit[k]   <= '0;
        en[k]      <= 1'b0;
        down[k]    <= 1'b0;
        auto_rl[k] <= 1'b0;
        wrap[k]    <= 1'b0;
`ifdef ESL_BUS_IRQ_EN
        ien[k]     <= 1'b0;
`endif
      end
    end else begin
      if (slave_read) slave_readdata <= rd;
      count   <= count_n;
      limit   <= limit_n;
      en      <= en_n;
      down    <= down_n;
      auto_rl <= auto_rl_n;
      wrap    <= wrap_n;
`ifdef ESL_BUS_IRQ_EN
      ien     <= ien_n;
`endif
    end
  end

`ifdef ESL_BUS_IRQ_EN
  logic irq_n;

  always_comb begin
    irq_n = 1'b0;
    for (int k = 0; k < N_CHANNELS; k++) irq_n = irq_n | (wrap[k] & ien[k]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= irq_n;
  end
`else
  // Without the IRQ feature CTRL[3] has no storage and always reads 0.
  always_comb begin
    for (int k = 0; k < N_CHANNELS; k++) ien[k] = 1'b0;
  end
`endif

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_led
    assign user_output[g*LED_WIDTH +: LED_WIDTH] = count[g][LED_WIDTH-1:0];
  end

endmodule

// File: tb/tb_esl_bus_multi_counter.sv
// Directed bench for esl_bus_multi_counter: register table vectors plus hand-written
// counting, collision, IRQ (when ESL_BUS_IRQ_EN is defined) and mid-run reset sequences.
module tb_esl_bus_multi_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  slave_address = '0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = '0;
  logic [3:0]  slave_byteenable = '0;
  logic [31:0] user_output;
`ifdef ESL_BUS_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;

  esl_bus_multi_counter dut (
    .clk              (clk),
    .reset            (reset),
    .slave_address    (slave_address),
    .slave_read       (slave_read),
    .slave_readdata   (slave_readdata),
    .slave_write      (slave_write),
    .slave_writedata  (slave_writedata),
    .slave_byteenable (slave_byteenable),
    .user_output      (user_output)
`ifdef ESL_BUS_IRQ_EN
    ,
    .irq              (irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [10];

  logic [7:0] seq_up   [6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h01};
  logic [7:0] seq_down [6] = '{8'h02, 8'h01, 8'h00, 8'h05, 8'h05, 8'h05};
  logic [7:0] seq_mod  [7] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    slave_address    = a;
    slave_writedata  = d;
    slave_byteenable = be;
    slave_write      = 1'b1;
    @(negedge clk);
    slave_write      = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    slave_address = a;
    slave_read    = 1'b1;
    @(negedge clk);
    slave_read    = 1'b0;
    d = slave_readdata;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rdv;

    vt[0] = '{8'h0A, 32'h00AABBCC, 4'b0010, 32'h0000BB00};
    vt[1] = '{8'h0A, 32'h11223344, 4'b1111, 32'h00223344};
    vt[2] = '{8'h0A, 32'h00000055, 4'b0001, 32'h00223355};
    vt[3] = '{8'h09, 32'hFFFFFFFF, 4'b1100, 32'h00FF0000};
    vt[4] = '{8'h08, 32'hFFFFFFF6, 4'b0001, 32'h00000006};
    vt[5] = '{8'h08, 32'h00000000, 4'b0000, 32'h00000006};
    vt[6] = '{8'h0B, 32'hFFFFFFFF, 4'b1111, 32'h00000000};
    vt[7] = '{8'h16, 32'h00000123, 4'b1111, 32'h00000000};
    vt[8] = '{8'hFD, 32'h000000FF, 4'b1111, 32'h00000000};
    vt[9] = '{8'h0D, 32'h00ABCDEF, 4'b0101, 32'h00AB00EF};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_readdata", slave_readdata, 32'h0);
    check("reset_leds", user_output, 32'h0);
`ifdef ESL_BUS_IRQ_EN
    check("reset_irq", {31'b0, irq}, 32'h0);
`endif
    reset = 1'b0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        bus_read(8'(c * 4 + r), rdv);
        check($sformatf("reset_reg_ch%0d_r%0d", c, r), rdv, 32'h0);
      end

    // Register access table on idle channels
    for (int i = 0; i < 10; i++) begin
      bus_write(vt[i].addr, vt[i].wdata, vt[i].be);
      bus_read(vt[i].addr, rdv);
      check($sformatf("vec%0d", i), rdv, vt[i].exp);
    end
    repeat (2) @(negedge clk);
    check("readdata_hold", slave_readdata, 32'h00AB00EF);

    // ch0 up-count with auto reload
    bus_write(8'h01, 32'd3, 4'hF);
    bus_write(8'h00, 32'h5, 4'hF);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("up_seq%0d", i), {24'b0, user_output[7:0]}, {24'b0, seq_up[i]});
      @(negedge clk);
    end
    bus_write(8'h00, 32'h0, 4'hF);
    bus_read(8'h03, rdv);
    check("up_wrap_set", rdv, 32'h1);
    bus_write(8'h03, 32'h1, 4'hF);
    bus_read(8'h03, rdv);
    check("up_wrap_clr", rdv, 32'h0);

    // ch1 one-shot down-count
    bus_write(8'h05, 32'd5, 4'hF);
    bus_write(8'h06, 32'd2, 4'hF);
    bus_write(8'h04, 32'h3, 4'hF);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("down_seq%0d", i), {24'b0, user_output[15:8]}, {24'b0, seq_down[i]});
      @(negedge clk);
    end
    bus_read(8'h07, rdv);
    check("down_status", rdv, 32'h1);
    bus_read(8'h04, rdv);
    check("down_ctrl_en_clr", rdv, 32'h2);
    bus_read(8'h06, rdv);
    check("down_count_hold", rdv, 32'h5);
    bus_write(8'h07, 32'h1, 4'b1110);
    bus_read(8'h07, rdv);
    check("w1c_be_masked", rdv, 32'h1);
    bus_write(8'h07, 32'h1, 4'b0001);
    bus_read(8'h07, rdv);
    check("w1c_be0", rdv, 32'h0);

    // COUNT write coincident with a terminal event
    bus_write(8'h00, 32'h5, 4'hF);
    repeat (3) @(negedge clk);
    check("coll_pre", {24'b0, user_output[7:0]}, 32'h3);
    slave_address    = 8'h02;
    slave_writedata  = 32'h10;
    slave_byteenable = 4'hF;
    slave_write      = 1'b1;
    @(negedge clk);
    slave_write      = 1'b0;
    check("coll_load", {24'b0, user_output[7:0]}, 32'h10);
    bus_read(8'h03, rdv);
    check("coll_no_wrap", rdv, 32'h2);
    bus_write(8'h00, 32'h0, 4'hF);

    // W1C coincident with a wrap (LIMIT=0 wraps every enabled cycle)
    bus_write(8'h01, 32'h0, 4'hF);
    bus_write(8'h02, 32'h0, 4'hF);
    bus_write(8'h00, 32'h5, 4'hF);
    bus_write(8'h03, 32'h1, 4'h1);
    bus_read(8'h03, rdv);
    check("w1c_set_wins", rdv, 32'h3);
    check("limit0_count", {24'b0, user_output[7:0]}, 32'h0);
    bus_write(8'h00, 32'h0, 4'hF);
    bus_write(8'h03, 32'h1, 4'h1);
    bus_read(8'h03, rdv);
    check("w1c_idle", rdv, 32'h0);

    // Count above LIMIT wraps modulo without an event
    bus_write(8'h01, 32'd2, 4'hF);
    bus_write(8'h02, 32'h00FFFFFE, 4'hF);
    bus_write(8'h00, 32'h1, 4'hF);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("mod_seq%0d", i), {24'b0, user_output[7:0]}, {24'b0, seq_mod[i]});
      @(negedge clk);
    end
    bus_read(8'h03, rdv);
    check("mod_status", rdv, 32'h1);

`ifdef ESL_BUS_IRQ_EN
    // IRQ timing on ch3
    bus_write(8'h0D, 32'd1, 4'hF);
    bus_write(8'h0C, 32'hD, 4'hF);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("irq_rise%0d", i), {31'b0, irq}, (i == 3) ? 32'h1 : 32'h0);
      @(negedge clk);
    end
    bus_write(8'h0C, 32'h8, 4'hF);
    check("irq_held", {31'b0, irq}, 32'h1);
    bus_write(8'h0F, 32'h1, 4'h1);
    check("irq_lag", {31'b0, irq}, 32'h1);
    @(negedge clk);
    check("irq_fall", {31'b0, irq}, 32'h0);
    bus_write(8'h0C, 32'hD, 4'hF);
    repeat (4) @(negedge clk);
    check("irq_rearm", {31'b0, irq}, 32'h1);
`endif

    // Asynchronous reset in the middle of counting
    bus_write(8'h05, 32'hFF, 4'hF);
    bus_write(8'h06, 32'h40, 4'hF);
    bus_write(8'h04, 32'h5, 4'hF);
    repeat (2) @(negedge clk);
    check("pre_reset_led1", {24'b0, user_output[15:8]}, 32'h42);
    #1 reset = 1'b1;
    #1;
    check("async_reset_leds", user_output, 32'h0);
    check("async_reset_readdata", slave_readdata, 32'h0);
`ifdef ESL_BUS_IRQ_EN
    check("async_reset_irq", {31'b0, irq}, 32'h0);
`endif
    @(negedge clk);
    reset = 1'b0;
    bus_read(8'h06, rdv);
    check("post_reset_ch1_count", rdv, 32'h0);
    bus_read(8'h0A, rdv);
    check("post_reset_ch2_count", rdv, 32'h0);
    bus_read(8'h08, rdv);
    check("post_reset_ch2_ctrl", rdv, 32'h0);
    bus_read(8'h0D, rdv);
    check("post_reset_ch3_limit", rdv, 32'h0);
    bus_read(8'h03, rdv);
    check("post_reset_ch0_status", rdv, 32'h0);
    check("post_reset_leds", user_output, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
